// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data side wins by default; a starvation counter forces fetch through, and a watchdog aborts hung accesses.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_ack,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_stall,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_ack,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    bus_err
);

  localparam int SC_WIDTH = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t              state, state_nxt;
  logic [SC_WIDTH-1:0] starve_cnt;
  logic [15:0]         wait_cnt;
  logic                busy, grant_d, grant_f, done_ok, timeout, finish;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    busy    = (state == FETCH) || (state == DATA);
    grant_d = (state == IDLE) && d_req &&
              (!if_req || (starve_cnt < SC_WIDTH'(STARVE_LIMIT)));
    grant_f = (state == IDLE) && !grant_d && if_req;
    done_ok = busy && mem_ready;
    // A response landing on the timeout edge is a normal completion, not an abort.
    timeout = busy && !mem_ready && (wait_cnt == 16'(TIMEOUT_CYCLES));
    finish  = done_ok || timeout;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (grant_d) state_nxt = DATA;
                   else if (grant_f) state_nxt = FETCH;
      FETCH, DATA: if (finish) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      bus_err    <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      if_ack <= finish && (state == FETCH);
      d_ack  <= finish && (state == DATA);

      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_be    <= d_be;
        wait_cnt  <= '0;
        if (!if_req)
          starve_cnt <= '0;
        else if (starve_cnt < SC_WIDTH'(STARVE_LIMIT))
          starve_cnt <= starve_cnt + 1'b1;
      end else if (grant_f) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= if_addr;
        mem_be     <= '1;
        wait_cnt   <= '0;
        starve_cnt <= '0;
      end else if (finish) begin
        mem_req <= 1'b0;
      end

      if (busy && !mem_ready)
        wait_cnt <= wait_cnt + 16'd1;

      // Aborted reads return zero so a stale word is never mistaken for real data.
      if (finish && (state == FETCH))
        if_rdata <= done_ok ? mem_rdata : '0;
      if (finish && (state == DATA) && !mem_we)
        d_rdata <= done_ok ? mem_rdata : '0;

      if (timeout)
        bus_err <= 1'b1;
    end
  end

  assign if_stall = if_req && !if_ack;
  assign d_stall  = d_req && !d_ack;

endmodule
